hdmi_audio_decimator: RTL and testbench

Clock-domain audio decimator that sits directly upstream of the HDMI top level's audio inputs. It receives signed 16-bit stereo PCM at an arbitrary per-cycle rate on the system clock. It box-filters (averages) all valid samples inside each output period and presents one averaged stereo sample per HDMI audio period (default FS = 32 kHz), matching the HDMI encoder's fixed FS. Output period is derived from a fractional NCO, so CLK_HZ need not be an integer multiple of FS.

---
 rtl/hdmi_audio_decimator.sv | 241 ++++++++++++++++++++++++
 tb/tb_hdmi_audio_decimator.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hdmi_audio_decimator.sv
// Box-filter decimator for the HDMI audio path. Averages every valid stereo
// sample that arrives within one output period and publishes one averaged
// stereo sample per period. A fractional NCO sets the period, so the clock
// rate does not need to be an integer multiple of the output rate.
module hdmi_audio_decimator #(
    parameter int CLK_HZ = 28000000,
    parameter int FS     = 32000,
    parameter int CNT_W  = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ce,
    input  logic signed [15:0] in_l,
    input  logic signed [15:0] in_r,
    input  logic               mute,
    output logic signed [15:0] audio_l,
    output logic signed [15:0] audio_r,
    output logic               strobe,
    output logic               busy
);

    localparam int                SUM_W     = 16 + CNT_W;
    localparam int                STEP_W    = $clog2(SUM_W);
    localparam logic [32:0]       FS_INC    = 33'(FS);
    localparam logic [32:0]       CLK_MOD   = 33'(CLK_HZ);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SUM_W - 1);

    // Refuse to elaborate when the divider could still be busy at the next
    // tick, or when the sample counter cannot hold a full window.
    localparam bit PARAMS_OK = (FS > 0) && (FS < CLK_HZ)
                            && ((SUM_W + 2) < (CLK_HZ / FS))
                            && (((CLK_HZ + FS - 1) / FS) < (2 ** CNT_W));

    generate
        if (!PARAMS_OK) begin : g_param_check
            $error("hdmi_audio_decimator: invalid CLK_HZ/FS/CNT_W combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_ACC,
        ST_DIV,
        ST_PUB
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [31:0]       phase_reg;
    logic [32:0]       phase_sum;
    logic              tick;
    logic              latch;
    logic              div_step;
    logic              pub;
    logic              busy_next;
    logic [STEP_W-1:0] step_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  div_cnt_reg;
    logic              cnt_zero_reg;
    logic              strobe_reg;

    // Phase accumulator: one tick each time the phase wraps past CLK_HZ.
    assign phase_sum = {1'b0, phase_reg} + FS_INC;
    assign tick      = (phase_sum >= CLK_MOD);

    // NCO phase register; the residue after a wrap carries into the next period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_reg <= '0;
        end else if (tick) begin
            phase_reg <= 32'(phase_sum - CLK_MOD);
        end else begin
            phase_reg <= phase_sum[31:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_ACC;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and control decode. A tick outside ACC is ignored so the
    // current window keeps accumulating.
    always_comb begin
        state_next = state_reg;
        latch      = 1'b0;
        div_step   = 1'b0;
        pub        = 1'b0;
        busy_next  = 1'b0;
        case (state_reg)
            ST_ACC: begin
                if (tick) begin
                    latch      = 1'b1;
                    state_next = ST_DIV;
                end
            end
            ST_DIV: begin
                busy_next = 1'b1;
                div_step  = 1'b1;
                if (step_reg == LAST_STEP) begin
                    state_next = ST_PUB;
                end
            end
            ST_PUB: begin
                pub        = 1'b1;
                state_next = ST_ACC;
            end
            default: begin
                state_next = ST_ACC;
            end
        endcase
    end

    // Divide step counter: one quotient bit per DIV cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_reg <= '0;
        end else if (latch) begin
            step_reg <= '0;
        end else if (div_step) begin
            step_reg <= step_reg + STEP_W'(1);
        end
    end

    // Shared sample counter; on a tick the tick-cycle sample opens the new window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (latch) begin
            count_reg <= {{(CNT_W-1){1'b0}}, ce};
        end else if (ce) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    // Divisor snapshot, plus a flag so an empty window republishes the old value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_reg  <= '0;
            cnt_zero_reg <= 1'b0;
        end else if (latch) begin
            div_cnt_reg  <= count_reg;
            cnt_zero_reg <= (count_reg == '0);
        end
    end

    // Strobe pulses for exactly the cycle after PUB.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            strobe_reg <= 1'b0;
        end else begin
            strobe_reg <= pub;
        end
    end

    // Per-channel accumulator and restoring divider (0 = left, 1 = right).
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic signed [15:0]      sample;
            logic signed [SUM_W-1:0] sample_ext;
            logic signed [SUM_W-1:0] sum_reg;
            logic [SUM_W-1:0]        sum_mag;
            logic [SUM_W-1:0]        quo_reg;
            logic [CNT_W-1:0]        rem_reg;
            logic [CNT_W:0]          rem_shift;
            logic [CNT_W-1:0]        rem_sub;
            logic                    rem_ge;
            logic                    neg_reg;
            logic [15:0]             quo_lo;
            logic [15:0]             result;
            logic signed [15:0]      audio_reg;

            assign sample     = (gi == 0) ? in_l : in_r;
            assign sample_ext = {{(SUM_W-16){sample[15]}}, sample};
            assign sum_mag    = sum_reg[SUM_W-1] ? $unsigned(-sum_reg) : $unsigned(sum_reg);

            // Restoring step: bring down the next dividend bit, subtract if it fits.
            // The true difference is below the divisor, so CNT_W bits of the
            // subtraction are exact.
            assign rem_shift = {rem_reg, quo_reg[SUM_W-1]};
            assign rem_ge    = (rem_shift >= {1'b0, div_cnt_reg});
            assign rem_sub   = rem_shift[CNT_W-1:0] - div_cnt_reg;

            // The average lies within the input range, so the low 16 quotient
            // bits are the whole magnitude; re-applying the sign afterwards
            // gives truncation toward zero.
            assign quo_lo = quo_reg[15:0];
            assign result = neg_reg ? (16'd0 - quo_lo) : quo_lo;

            // Running sum; reloads with the tick-cycle sample when a window closes.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sum_reg <= '0;
                end else if (latch) begin
                    sum_reg <= ce ? sample_ext : '0;
                end else if (ce) begin
                    sum_reg <= sum_reg + sample_ext;
                end
            end

            // Divider datapath: load |sum| on latch, shift one quotient bit per step.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    quo_reg <= '0;
                    rem_reg <= '0;
                    neg_reg <= 1'b0;
                end else if (latch) begin
                    quo_reg <= sum_mag;
                    rem_reg <= '0;
                    neg_reg <= sum_reg[SUM_W-1];
                end else if (div_step) begin
                    quo_reg <= {quo_reg[SUM_W-2:0], rem_ge};
                    rem_reg <= rem_ge ? rem_sub : rem_shift[CNT_W-1:0];
                end
            end

            // Output register: updates only in PUB; mute wins, empty window holds.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    audio_reg <= '0;
                end else if (pub) begin
                    if (mute) begin
                        audio_reg <= '0;
                    end else if (!cnt_zero_reg) begin
                        audio_reg <= $signed(result);
                    end
                end
            end
        end
    endgenerate

    assign audio_l = g_chan[0].audio_reg;
    assign audio_r = g_chan[1].audio_reg;
    assign strobe  = strobe_reg;
    assign busy    = busy_next;

endmodule

// File: tb/tb_hdmi_audio_decimator.sv
// Directed bench for hdmi_audio_decimator at default parameters
// (875-cycle output period, 27-cycle tick-to-strobe latency).
module tb_hdmi_audio_decimator;

    logic               clk;
    logic               reset_n;
    logic               ce;
    logic signed [15:0] in_l;
    logic signed [15:0] in_r;
    logic               mute;
    logic signed [15:0] audio_l;
    logic signed [15:0] audio_r;
    logic               strobe;
    logic               busy;

    int checks   = 0;
    int failures = 0;
    bit alt_mode = 1'b0;
    int waited;
    int n;

    hdmi_audio_decimator dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .in_l    (in_l),
        .in_r    (in_r),
        .mute    (mute),
        .audio_l (audio_l),
        .audio_r (audio_r),
        .strobe  (strobe),
        .busy    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance cycle by cycle (sampling 1 time unit after each edge) until
    // strobe is seen or the budget runs out; returns cycles waited.
    task automatic wait_strobe(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
            if (alt_mode) begin
                in_l = (in_l == 16'sd1) ? 16'sd0 : 16'sd1;
                in_r = -in_l;
            end
        end while (!strobe && cycles < 2000);
        check("strobe_seen", strobe, 1);
        $display("strobe after %0d cycles: audio_l=%0d audio_r=%0d", cycles, audio_l, audio_r);
    endtask

    initial begin
        reset_n = 1'b0;
        ce      = 1'b1;
        in_l    = 16'sd1000;
        in_r    = -16'sd1000;
        mute    = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_audio_l", audio_l, 0);
        check("rst_audio_r", audio_r, 0);
        check("rst_strobe", strobe, 0);
        check("rst_busy", busy, 0);

        // Constant 1000/-1000: first strobe after 875+27 edges, then 875 spacing
        @(negedge clk);
        reset_n = 1'b1;
        wait_strobe(waited);
        check("first_latency", waited, 902);
        check("const_l", audio_l, 1000);
        check("const_r", audio_r, -1000);
        wait_strobe(waited);
        check("period", waited, 875);
        check("const2_l", audio_l, 1000);
        check("const2_r", audio_r, -1000);
        @(posedge clk);
        #1;
        check("strobe_one_cycle", strobe, 0);

        // Busy spans exactly the 26 divide cycles, strobe follows PUB
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!busy && n < 2000);
        check("busy_seen", busy, 1);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("busy_cycles", n, 26);
        check("strobe_in_pub", strobe, 0);
        @(posedge clk);
        #1;
        check("strobe_after_pub", strobe, 1);

        // Alternating 1/0 and -1/0: average truncates toward zero
        alt_mode = 1'b1;
        in_l = 16'sd1;
        in_r = -16'sd1;
        wait_strobe(waited);
        wait_strobe(waited);
        check("alt_l", audio_l, 0);
        check("alt_r", audio_r, 0);
        alt_mode = 1'b0;

        // Full-scale negative input must not wrap
        in_l = 16'sh8000;
        in_r = 16'sh8000;
        wait_strobe(waited);
        wait_strobe(waited);
        check("fullscale_l", audio_l, -32768);
        check("fullscale_r", audio_r, -32768);

        // 500/500, then an empty window republishes 500/500
        in_l = 16'sd500;
        in_r = 16'sd500;
        wait_strobe(waited);
        wait_strobe(waited);
        check("v500_l", audio_l, 500);
        check("v500_r", audio_r, 500);
        ce = 1'b0;
        wait_strobe(waited);
        check("partial_l", audio_l, 500);
        check("partial_r", audio_r, 500);
        wait_strobe(waited);
        check("empty_period", waited, 875);
        check("empty_l", audio_l, 500);
        check("empty_r", audio_r, 500);

        // Mute during PUB forces 0/0, outputs hold, then 1234 returns
        ce   = 1'b1;
        in_l = 16'sd1234;
        in_r = 16'sd1234;
        wait_strobe(waited);
        wait_strobe(waited);
        check("v1234_l", audio_l, 1234);
        check("v1234_r", audio_r, 1234);
        mute = 1'b1;
        wait_strobe(waited);
        check("mute_l", audio_l, 0);
        check("mute_r", audio_r, 0);
        mute = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("hold_l", audio_l, 0);
        wait_strobe(waited);
        check("unmute_l", audio_l, 1234);
        check("unmute_r", audio_r, 1234);

        // Reset 10 cycles into DIV clears everything immediately
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!busy && n < 2000);
        check("busy_before_rst", busy, 1);
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_audio_l", audio_l, 0);
        check("midrst_audio_r", audio_r, 0);
        check("midrst_strobe", strobe, 0);
        check("midrst_busy", busy, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        wait_strobe(waited);
        check("post_rst_latency", waited, 902);
        check("post_rst_l", audio_l, 1234);
        check("post_rst_r", audio_r, 1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
